arb_requester: RTL



---
 rtl/arb_requester.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/arb_requester.sv
// arb_requester: requester-side agent for one port of a two-way round-robin
// arbiter. Buffers upstream valid/ready transactions in a small FIFO, raises
// req while work is pending, and on each grant presents one entry for a single
// cycle on the shared-bus output.
// Optional feature: define ARB_REQ_TIMEOUT_EN to enable the grant-wait
// watchdog (wait counter + sticky timeout flag); otherwise timeout is tied 0.
module arb_requester #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       in_ready,
    output logic                       req,
    input  logic                       grant,
    output logic                       bus_valid,
    output logic [DATA_WIDTH-1:0]      bus_data,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       spurious_gnt,
    output logic                       timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Reject configurations the pointer arithmetic cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("arb_requester: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  push;
    logic                  pop;
    state_t                state_q;
    state_t                state_d;

    assign push    = in_valid && in_ready;
    assign pop     = grant && (count != '0);
    assign pending = count;

    // While in reset the block must look empty and ready to the outside world.
    assign in_ready = !reset_n || (count != CW'(DEPTH));
    // req already excludes the entry being granted this cycle, so the arbiter
    // never samples req high for an entry that is about to be consumed.
    assign req      = reset_n && ((count - CW'(pop)) != '0);

    // Payload storage write port.
    // NOTE: the storage array has no reset; pointers and count define validity,
    // so clearing contents would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Bus strobe and payload on each real pop; sticky spurious-grant flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_valid    <= 1'b0;
            bus_data     <= '0;
            spurious_gnt <= 1'b0;
        end else begin
            bus_valid <= pop;
            if (pop) begin
                bus_data <= mem[rd_ptr];
            end
            if (grant && (count == '0)) begin
                spurious_gnt <= 1'b1;
            end
        end
    end

    // Grant-wait state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: WAIT while the FIFO holds work, IDLE once drained.
    // NOTE: state_d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (push) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pop && !push && (count == CW'(1))) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt;
    logic [TW-1:0] wait_cnt_d;
    logic          timeout_q;

    // Count ungranted WAIT cycles, saturating; a pop (the only way out of
    // WAIT) or being outside WAIT clears it.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == S_WAIT && !pop) begin
            wait_cnt_d = (wait_cnt == TW'(TIMEOUT_CYCLES)) ? wait_cnt : wait_cnt + 1'b1;
        end
    end

    // Wait counter register and sticky watchdog flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_d;
            if (wait_cnt_d == TW'(TIMEOUT_CYCLES)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule
